uncached_axi_bridge: RTL and testbench

- Bus-side end of the data address path: takes a physical-address load/store request from the memory stage (address already translated by the fixed-segment mapper) and performs it as one single-beat AXI transaction.
- Returns load data or a store acknowledge to the pipeline.
- Used for uncached (kseg1-class) accesses and for all data accesses while no cache is present.
- Strictly one outstanding transaction.

---
 rtl/uncached_axi_bridge_pkg.sv | 20 ++
 rtl/uncached_axi_bridge.sv | 173 +++++++++++++++++
 tb/tb_uncached_axi_bridge.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uncached_axi_bridge_pkg.sv
// Shared encodings for the uncached data-side AXI bridge:
// FSM states, AXI burst/response codes and access sizes.
package uncached_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW_W = 3'd3,
        B    = 3'd4
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/uncached_axi_bridge.sv
// Single-outstanding bridge turning a physical load/store request
// into one single-beat AXI transaction, returning data or an ack.
module uncached_axi_bridge
    import uncached_axi_bridge_pkg::*;
#(
    parameter int ID_W  = 4,
    parameter int RD_ID = 0,
    parameter int WR_ID = 1
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req_valid,
    input  logic            req_wr,
    input  logic [1:0]      req_size,
    input  logic [31:0]     req_addr,
    input  logic [3:0]      req_wstrb,
    input  logic [31:0]     req_wdata,
    output logic            req_ready,
    output logic            rsp_valid,
    output logic [31:0]     rsp_rdata,
    output logic            rsp_err,

    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,

    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,

    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,

    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,

    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    state_e      state_q, state_d;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic        accept;
    logic        aw_hs;
    logic        w_hs;

    // With one transaction in flight the IDs and rlast carry no information.
    logic unused_in;
    assign unused_in = ^{rid, bid, rlast};

    assign req_ready = (state_q == IDLE) & ~rst;
    assign accept    = req_ready & req_valid;
    assign aw_hs     = awvalid & awready;
    assign w_hs      = wvalid & wready;

    assign arid    = ID_W'(RD_ID);
    assign awid    = ID_W'(WR_ID);
    assign arlen   = 8'd0;
    assign awlen   = 8'd0;
    assign arburst = AXI_BURST_INCR;
    assign awburst = AXI_BURST_INCR;
    assign arsize  = {1'b0, size_q};
    assign awsize  = {1'b0, size_q};
    assign araddr  = addr_q;
    assign awaddr  = addr_q;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    always_comb begin
        state_d = state_q;
        arvalid = 1'b0;
        rready  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = req_wr ? AW_W : AR;
            end
            AR: begin
                arvalid = 1'b1;
                if (arready) state_d = R;
            end
            R: begin
                rready = 1'b1;
                if (rvalid) state_d = IDLE;
            end
            AW_W: begin
                awvalid = ~aw_done_q;
                wvalid  = ~w_done_q;
                // Address and data channels may complete in either order.
                if ((aw_done_q | (awready & ~aw_done_q)) &
                    (w_done_q | (wready & ~w_done_q)))
                    state_d = B;
            end
            B: begin
                bready = 1'b1;
                if (bvalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            size_q      <= 2'd0;
            addr_q      <= 32'd0;
            wstrb_q     <= 4'd0;
            wdata_q     <= 32'd0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            if (accept) begin
                size_q    <= req_size;
                addr_q    <= req_addr;
                wstrb_q   <= req_wstrb;
                wdata_q   <= req_wdata;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (rready & rvalid) begin
                rsp_valid_q <= 1'b1;
                rsp_rdata_q <= rdata;
                rsp_err_q   <= (rresp != AXI_RESP_OKAY);
            end
            if (bready & bvalid) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= (bresp != AXI_RESP_OKAY);
            end
        end
    end

endmodule

// File: tb/tb_uncached_axi_bridge.sv
// Directed bench for uncached_axi_bridge: loads, stores, error
// responses, back-to-back accept and mid-transaction reset.
module tb_uncached_axi_bridge;

    localparam int ID_W = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid, req_wr;
    logic [1:0]      req_size;
    logic [31:0]     req_addr, req_wdata;
    logic [3:0]      req_wstrb;
    logic            req_ready, rsp_valid, rsp_err;
    logic [31:0]     rsp_rdata;
    logic [ID_W-1:0] arid, awid, rid, bid;
    logic [31:0]     araddr, awaddr, rdata, wdata;
    logic [7:0]      arlen, awlen;
    logic [2:0]      arsize, awsize;
    logic [1:0]      arburst, awburst, rresp, bresp;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic            awvalid, awready, wlast, wvalid, wready;
    logic [3:0]      wstrb;
    logic            bvalid, bready;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uncached_axi_bridge #(.ID_W(ID_W), .RD_ID(0), .WR_ID(1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_size(req_size),
        .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 0; req_wr = 0; req_size = 0; req_addr = 0;
        req_wstrb = 0; req_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 1; bresp = 0; bvalid = 0;
        tick();
        tick();
        chk("rst_req_ready", 32'(req_ready), 0);
        rst = 1'b0;
        #1;
        chk("idle_req_ready", 32'(req_ready), 1);
        chk("idle_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        chk("idle_rsp", {rsp_valid, rsp_err}, 0);
        chk("idle_rdata", rsp_rdata, 0);
        chk("idle_araddr", araddr, 0);
        chk("fixed_len", {arlen, awlen}, 0);
        chk("fixed_burst", {arburst, awburst}, 32'h5);
        chk("fixed_ids", {arid, awid}, 32'h01);
        chk("fixed_wlast", 32'(wlast), 1);

        // Load word, arready delayed two cycles
        req_valid = 1; req_wr = 0; req_size = 2; req_addr = 32'h1FC0_0010;
        #1;
        chk("ld_accept", 32'(req_ready), 1);
        tick();
        req_valid = 0;
        #1;
        chk("ld_arvalid", 32'(arvalid), 1);
        chk("ld_araddr", araddr, 32'h1FC0_0010);
        chk("ld_arsize", 32'(arsize), 2);
        chk("ld_busy", 32'(req_ready), 0);
        tick();
        chk("ld_ar_hold1", 32'(arvalid), 1);
        tick();
        chk("ld_ar_hold2", 32'(arvalid), 1);
        arready = 1;
        tick();
        arready = 0;
        #1;
        chk("ld_rready", {arvalid, rready}, 32'h1);
        rvalid = 1; rdata = 32'hDEAD_BEEF; rresp = 0;
        #1;
        chk("ld_no_early_rsp", 32'(rsp_valid), 0);
        tick();
        rvalid = 0;
        #1;
        chk("ld_rsp_valid", 32'(rsp_valid), 1);
        chk("ld_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("ld_rsp_err", 32'(rsp_err), 0);
        chk("ld_idle_again", 32'(req_ready), 1);
        tick();
        chk("ld_rsp_pulse", 32'(rsp_valid), 0);

        // Store byte, wready three cycles before awready
        req_valid = 1; req_wr = 1; req_size = 0; req_addr = 32'h3;
        req_wstrb = 4'b1000; req_wdata = 32'h5500_0000;
        tick();
        req_valid = 0;
        #1;
        chk("st_aw_w", {awvalid, wvalid}, 32'h3);
        chk("st_awaddr", awaddr, 32'h3);
        chk("st_awsize", 32'(awsize), 0);
        chk("st_wstrb", 32'(wstrb), 32'h8);
        chk("st_wdata", wdata, 32'h5500_0000);
        wready = 1;
        tick();
        wready = 0;
        #1;
        chk("st_w_drop", {awvalid, wvalid}, 32'h2);
        tick();
        chk("st_aw_hold1", {awvalid, wvalid, bready}, 32'h4);
        tick();
        chk("st_aw_hold2", {awvalid, wvalid, bready}, 32'h4);
        awready = 1;
        tick();
        awready = 0;
        #1;
        chk("st_in_b", {awvalid, wvalid, bready}, 32'h1);
        bvalid = 1; bresp = 0;
        tick();
        bvalid = 0;
        #1;
        chk("st_rsp", {rsp_valid, rsp_err}, 32'h2);
        tick();
        chk("st_rsp_pulse", 32'(rsp_valid), 0);

        // Store with simultaneous awready/wready and non-OKAY bresp
        req_valid = 1; req_wr = 1; req_size = 2; req_addr = 32'h8000_0100;
        req_wstrb = 4'hF; req_wdata = 32'hCAFE_F00D;
        tick();
        req_valid = 0;
        awready = 1; wready = 1;
        #1;
        chk("st2_both", {awvalid, wvalid}, 32'h3);
        tick();
        awready = 0; wready = 0;
        #1;
        chk("st2_in_b", {awvalid, wvalid, bready}, 32'h1);
        bvalid = 1; bresp = 2'b01;
        tick();
        bvalid = 0; bresp = 0;
        #1;
        chk("st2_rsp_err", {rsp_valid, rsp_err}, 32'h3);
        tick();
        chk("st2_err_pulse", {rsp_valid, rsp_err}, 0);

        // Load with SLVERR, then back-to-back request in rsp cycle
        req_valid = 1; req_wr = 0; req_size = 2; req_addr = 32'h1000_0004;
        tick();
        req_valid = 0;
        arready = 1;
        tick();
        arready = 0;
        rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b10;
        tick();
        rvalid = 0; rresp = 0;
        req_valid = 1; req_size = 1; req_addr = 32'hA000_0020;
        #1;
        chk("err_rsp", {rsp_valid, rsp_err}, 32'h3);
        chk("err_rdata", rsp_rdata, 32'h1234_5678);
        chk("b2b_ready", 32'(req_ready), 1);
        tick();
        req_valid = 0;
        #1;
        chk("b2b_arvalid", 32'(arvalid), 1);
        chk("b2b_araddr", araddr, 32'hA000_0020);
        chk("b2b_arsize", 32'(arsize), 1);
        chk("b2b_rsp_low", 32'(rsp_valid), 0);

        // Reset while waiting in R
        arready = 1;
        tick();
        arready = 0;
        #1;
        chk("rst_in_r", 32'(rready), 1);
        rst = 1;
        #1;
        chk("rst_blocks_ready", 32'(req_ready), 0);
        tick();
        rst = 0;
        #1;
        chk("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        chk("rst_req_ready2", 32'(req_ready), 1);
        chk("rst_no_rsp", {rsp_valid, rsp_err}, 0);
        chk("rst_rdata", rsp_rdata, 0);
        tick();
        chk("rst_no_rsp2", 32'(rsp_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
